// File: rtl/dmem_pkg.sv
// Shared encodings, capture-stage record and store-lane helpers for the dmem initiator.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // op: 1 = store, 0 = load. The command tag rides beside this record so its width can follow ID_W.
    typedef struct packed {
        logic       op;
        logic [1:0] off;
        logic [1:0] size;
        logic       sgn;
        logic       err;
    } cap_t;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } lane_t;

    function automatic lane_t store_lanes(input logic [1:0] size, input logic [1:0] off,
                                          input logic [31:0] d);
        lane_t l;
        case (size)
            SZ_BYTE: begin
                l.wstrb = 4'b0001 << off;
                l.wdata = {4{d[7:0]}};
            end
            SZ_HALF: begin
                l.wstrb = 4'b0011 << off;
                l.wdata = {2{d[15:0]}};
            end
            default: begin
                l.wstrb = 4'hF;
                l.wdata = d;
            end
        endcase
        return l;
    endfunction

    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'd0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; push and pop may coincide at any fill level, including full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/dmem_initiator.sv
// In-order load/store command stream to the single-cycle dmem port.
// Issue and capture stages feed a response FIFO; credits bound the commands in flight.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int ID_W      = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [31:0]     cmd_addr,
    input  logic [1:0]      cmd_size,
    input  logic            cmd_signed,
    input  logic [31:0]     cmd_wdata,
    input  logic [ID_W-1:0] cmd_id,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [ID_W-1:0] rsp_id,
    output logic            rsp_error,
    input  logic            stall,
    output logic            dmem_valid,
    output logic [31:0]     dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [31:0]     dmem_wdata,
    input  logic [31:0]     dmem_rdata
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int RSP_W = 32 + ID_W + 1;

    logic            r_run;
    logic            r_iss_busy;
    cap_t            r_iss_meta;
    logic [ID_W-1:0] r_iss_id;
    logic            r_cap_busy;
    cap_t            r_cap_meta;
    logic [ID_W-1:0] r_cap_id;
    logic            r_dmem_valid;
    logic [31:0]     r_dmem_addr;
    logic [3:0]      r_dmem_wstrb;
    logic [31:0]     r_dmem_wdata;

    logic             w_iss_stalled;
    logic             w_iss_adv;
    logic             w_accept;
    logic             w_err;
    lane_t            w_lanes;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_used;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_rsp_data;
    logic [RSP_W-1:0] w_fifo_dout;

    // Every command holds a credit from acceptance until its response leaves the FIFO.
    assign w_used        = {1'b0, w_fifo_count} + (CNT_W+1)'(r_iss_busy) + (CNT_W+1)'(r_cap_busy);
    assign w_iss_stalled = r_dmem_valid && stall;
    assign w_iss_adv     = r_iss_busy && !w_iss_stalled;
    assign cmd_ready     = r_run && !w_iss_stalled && (w_used < (CNT_W+1)'(RSP_DEPTH));
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_err         = is_bad_access(cmd_size, cmd_addr[1:0]);
    assign w_lanes       = store_lanes(cmd_size, cmd_addr[1:0], cmd_wdata);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_run        <= 1'b0;
            r_iss_busy   <= 1'b0;
            r_iss_meta   <= '0;
            r_iss_id     <= '0;
            r_dmem_valid <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wstrb <= '0;
            r_dmem_wdata <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                // Bad accesses still occupy the issue slot so responses stay in command order.
                r_iss_busy   <= 1'b1;
                r_dmem_valid <= !w_err;
                r_dmem_addr  <= {cmd_addr[31:2], 2'b00};
                r_dmem_wstrb <= (cmd_write && !w_err) ? w_lanes.wstrb : 4'h0;
                r_dmem_wdata <= cmd_write ? w_lanes.wdata : 32'h0;
                r_iss_meta   <= '{op: cmd_write, off: cmd_addr[1:0], size: cmd_size,
                                  sgn: cmd_signed, err: w_err};
                r_iss_id     <= cmd_id;
            end else if (w_iss_adv) begin
                r_iss_busy   <= 1'b0;
                r_dmem_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cap_busy <= 1'b0;
            r_cap_meta <= '0;
            r_cap_id   <= '0;
        end else begin
            r_cap_busy <= w_iss_adv;
            if (w_iss_adv) begin
                r_cap_meta <= r_iss_meta;
                r_cap_id   <= r_iss_id;
            end
        end
    end

    always_comb begin
        w_byte     = dmem_rdata[{r_cap_meta.off, 3'b000} +: 8];
        w_half     = dmem_rdata[{r_cap_meta.off[1], 4'b0000} +: 16];
        w_rsp_data = '0;
        if (!r_cap_meta.err && !r_cap_meta.op) begin
            case (r_cap_meta.size)
                SZ_BYTE: w_rsp_data = {{24{r_cap_meta.sgn && w_byte[7]}}, w_byte};
                SZ_HALF: w_rsp_data = {{16{r_cap_meta.sgn && w_half[15]}}, w_half};
                default: w_rsp_data = dmem_rdata;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (r_cap_busy),
        .i_data  ({w_rsp_data, r_cap_id, r_cap_meta.err}),
        .i_pop   (rsp_ready),
        .o_valid (rsp_valid),
        .o_data  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

    assign rsp_data   = w_fifo_dout[RSP_W-1 -: 32];
    assign rsp_id     = w_fifo_dout[ID_W:1];
    assign rsp_error  = w_fifo_dout[0];
    assign dmem_valid = r_dmem_valid;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wstrb = r_dmem_wstrb;
    assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: byte-level memory reference model, request/response scoreboards,
// directed scenarios followed by randomized traffic with random stall and response back-pressure.
module tb_dmem_initiator;
    localparam int RSP_DEPTH = 4;
    localparam int ID_W      = 4;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            cmd_valid, cmd_ready, cmd_write, cmd_signed;
    logic [31:0]     cmd_addr, cmd_wdata;
    logic [1:0]      cmd_size;
    logic [ID_W-1:0] cmd_id;
    logic            rsp_valid, rsp_ready, rsp_error;
    logic [31:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic            stall, dmem_valid;
    logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_wstrb;

    always #5 clock = ~clock;

    dmem_initiator #(.RSP_DEPTH(RSP_DEPTH), .ID_W(ID_W)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_signed(cmd_signed),
        .cmd_wdata(cmd_wdata), .cmd_id(cmd_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_error(rsp_error),
        .stall(stall), .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic            wr;
        logic [31:0]     addr;
        logic [1:0]      size;
        logic            sgn;
        logic [31:0]     wdata;
        logic [ID_W-1:0] id;
    } cmd_s;
    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
        logic            err;
    } rsp_s;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_s;

    cmd_s cmd_q[$];
    rsp_s exp_q[$];
    rsp_s got_q[$];
    req_s req_q[$];

    logic [7:0]  ref_mem [1024];
    logic [31:0] dev_mem [256];
    logic [31:0] nxt_rdata;

    int n_chk = 0, n_err = 0;
    int n_acc = 0, n_bp = 0, n_rsp = 0;
    int stall_mode = 0;   // 0 low, 1 forced high, 2 random
    int rr_mode = 0;      // 0 low, 1 high, 2 random

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte memory; the expected response and dmem request come from the access rules.
    task automatic model_accept(input cmd_s c);
        int          nb;
        logic        err;
        rsp_s        r;
        req_s        q;
        logic [31:0] v;
        nb    = 1 << c.size;
        err   = (c.size == 2'd3) || ((c.addr & 32'(nb - 1)) != 0);
        r.id  = c.id;
        r.err = err;
        r.data = '0;
        if (!err) begin
            q.wr = c.wr; q.addr = c.addr & ~32'h3; q.wstrb = '0; q.wdata = '0;
            if (c.wr) begin
                for (int i = 0; i < nb; i++) begin
                    q.wstrb[int'(c.addr[1:0]) + i] = 1'b1;
                    ref_mem[int'(c.addr[9:0]) + i] = c.wdata[8*i +: 8];
                end
                for (int j = 0; j < 4; j++) q.wdata[8*j +: 8] = c.wdata[8*(j % nb) +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(c.addr[9:0]) + i]) << (8*i));
                if (c.sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                r.data = v;
            end
            req_q.push_back(q);
        end
        exp_q.push_back(r);
    endtask

    // Command/stall/rsp_ready driver; handshakes sampled at the falling edge.
    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_signed = 0;
        cmd_wdata = 0; cmd_id = 0; stall = 0; rsp_ready = 0;
        forever begin
            @(posedge clock); #1;
            if (cmd_q.size() != 0) begin
                cmd_valid = 1; cmd_write = cmd_q[0].wr; cmd_addr = cmd_q[0].addr;
                cmd_size = cmd_q[0].size; cmd_signed = cmd_q[0].sgn;
                cmd_wdata = cmd_q[0].wdata; cmd_id = cmd_q[0].id;
            end else begin
                cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            stall     = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 3) == 0);
            rsp_ready = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 9) < 7);
            @(negedge clock);
            if (cmd_valid && cmd_ready) begin
                model_accept(cmd_q.pop_front());
                n_acc++;
            end
            if (cmd_valid && !cmd_ready) n_bp++;
        end
    end

    // Memory responder and request monitor.
    initial begin
        nxt_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (dmem_valid) begin
                if (req_q.size() == 0) chk("req_unexpected", 32'(dmem_valid), 0);
                else begin
                    chk("req_addr", dmem_addr, req_q[0].addr);
                    chk("req_wstrb", 32'(dmem_wstrb), 32'(req_q[0].wstrb));
                    if (req_q[0].wr) chk("req_wdata", dmem_wdata, req_q[0].wdata);
                    if (stall) chk("ready_in_stall", 32'(cmd_ready), 0);
                    else begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_wstrb[b]) dev_mem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                        nxt_rdata = dev_mem[dmem_addr[9:2]];
                        void'(req_q.pop_front());
                    end
                end
            end
            if (!(dmem_valid && !stall)) nxt_rdata = $urandom;
        end
    end

    initial begin
        dmem_rdata = 32'h0;
        forever begin
            @(posedge clock); #1;
            dmem_rdata = nxt_rdata;
        end
    end

    // Response scoreboard; also checks that a held response stays stable.
    initial begin
        rsp_s r;
        forever begin
            @(negedge clock);
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                else begin
                    r = exp_q[0];
                    chk("rsp_data", rsp_data, r.data);
                    chk("rsp_id", 32'(rsp_id), 32'(r.id));
                    chk("rsp_error", 32'(rsp_error), 32'(r.err));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back('{data: rsp_data, id: rsp_id, err: rsp_error});
                        n_rsp++;
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata, input logic [ID_W-1:0] id);
        cmd_q.push_back('{wr: wr, addr: addr, size: size, sgn: sgn, wdata: wdata, id: id});
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk("drain_left", 32'(cmd_q.size() + exp_q.size() + req_q.size()), 0);
    endtask

    initial begin
        int n0, b0, r0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) dev_mem[i] = 32'h0;

        #23;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_dmem_valid", 32'(dmem_valid), 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wstrb", 32'(dmem_wstrb), 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id_err", {27'(rsp_id), rsp_error}, 0);
        @(negedge clock); #2 resetn = 1;
        rr_mode = 1;

        // Directed load/store sequence
        got_q.delete();
        push_cmd(1, 32'h100, 2, 0, 32'hDEADBEEF, 1);
        push_cmd(0, 32'h100, 2, 0, 32'h0, 2);
        push_cmd(1, 32'h103, 0, 0, 32'h123456A5, 3);
        push_cmd(0, 32'h103, 0, 1, 32'h0, 4);
        push_cmd(0, 32'h103, 0, 0, 32'h0, 5);
        push_cmd(0, 32'h100, 2, 0, 32'h0, 6);
        push_cmd(0, 32'h101, 1, 0, 32'h0, 7);
        push_cmd(0, 32'h100, 2, 0, 32'h0, 8);
        wait_drain(200);
        chk("dir_count", 32'(got_q.size()), 8);
        if (got_q.size() == 8) begin
            chk("dir_word_load", got_q[1].data, 32'hDEADBEEF);
            chk("dir_sbyte", got_q[3].data, 32'hFFFFFFA5);
            chk("dir_ubyte", got_q[4].data, 32'h000000A5);
            chk("dir_word_after_byte", got_q[5].data, 32'hA5ADBEEF);
            chk("dir_half_err", {got_q[6].err, 27'(got_q[6].id)}, {1'b1, 27'd7});
            chk("dir_half_data", got_q[6].data, 0);
            chk("dir_order_after", 32'(got_q[7].id), 8);
        end

        // Credit limit with responses held off
        rr_mode = 0;
        n0 = n_acc;
        for (int k = 0; k < 6; k++) push_cmd(0, 32'h100 + 4*k, 2, 0, 0, 4'(k + 9));
        repeat (20) @(negedge clock);
        chk("credit_accepted", 32'(n_acc - n0), 4);
        chk("credit_ready_low", 32'(cmd_ready), 0);
        rr_mode = 1;
        wait_drain(200);
        chk("credit_all", 32'(n_acc - n0), 6);

        // Stall held on an issued load
        stall_mode = 1;
        r0 = n_rsp;
        push_cmd(0, 32'h100, 2, 0, 0, 4'hA);
        for (int i = 0; i < 20 && !dmem_valid; i++) @(negedge clock);
        chk("stall_issue", 32'(dmem_valid), 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold_valid", 32'(dmem_valid), 1);
            chk("stall_hold_addr", dmem_addr, 32'h100);
            if (i < 2) @(negedge clock);
        end
        stall_mode = 0;
        wait_drain(200);
        chk("stall_one_rsp", 32'(n_rsp - r0), 1);

        // Full throughput: no back-pressure with a free responder and consumer
        b0 = n_bp;
        for (int k = 0; k < 8; k++) push_cmd(k[0], 32'h200 + 4*k, 2, 0, $urandom, 4'(k));
        wait_drain(200);
        chk("throughput_bp", 32'(n_bp - b0), 0);

        // Reset with loads in flight
        rr_mode = 0;
        n0 = n_acc;
        push_cmd(0, 32'h100, 2, 0, 0, 4'h1);
        push_cmd(0, 32'h104, 2, 0, 0, 4'h2);
        for (int i = 0; i < 20 && (n_acc - n0) < 2; i++) @(negedge clock);
        chk("rst_mid_accepted", 32'(n_acc - n0), 2);
        @(negedge clock);
        #2 resetn = 0;
        #1;
        chk("rst_mid_dmem_valid", 32'(dmem_valid), 0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        exp_q.delete();
        req_q.delete();
        repeat (2) @(negedge clock);
        #2 resetn = 1;
        rr_mode = 1;
        repeat (10) @(negedge clock);
        chk("rst_no_stale", 32'(rsp_valid), 0);

        // Randomized traffic
        stall_mode = 2;
        rr_mode = 2;
        for (int k = 0; k < 400; k++)
            push_cmd(1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, 4'($urandom));
        wait_drain(20000);
        stall_mode = 0;
        rr_mode = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
